instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage between the program ROM and the decode/execute unit.
//  - Owns the program counter (PC) and drives the ROM address and read/enable strobes.
//  - Assembles 1- or 2-byte instructions and presents them to decode over a valid/ready handshake.
//  - Accepts PC redirects from execute (JMP/ACL/RET) and stops fetching after HLT.
// PARAMETERS
//  START_ADDR  8'h00  PC value loaded on reset
// PORTS
//  clk           in   1  clock; all state updates on the rising edge
//  rst_n         in   1  asynchronous active-low reset
//  rom_addr      out  8  ROM address (= PC)
//  rom_read      out  1  ROM read strobe
//  rom_ena       out  1  ROM enable
//  rom_data      in   8  ROM data, combinational from rom_addr in the same cycle
//  ir_valid      out  1  instruction bundle valid
//  ir_ready      in   1  decode accepts the bundle
//  ir_opcode     out  4  opcode byte [7:4]
//  ir_reg        out  4  opcode byte [3:0], the register/field nibble
//  ir_operand    out  8  second byte; 8'h00 for 1-byte instructions
//  ir_pc         out  8  address of the opcode byte
//  ir_two_byte   out  1  bundle carries an operand byte
//  pc_load       in   1  redirect request from execute
//  pc_load_addr  in   8  redirect target
//  halted        out  1  high in the HALTED state
// BEHAVIOUR
//  - Reset (async, rst_n=0): PC=START_ADDR, state=FETCH_OP, all ir_* and halted =0.
//  - Reset mid-operation aborts any fetch immediately.
//  - Two-byte opcodes: 0001 LDO, 0010 LDA, 0011 STO, 0101 JMP, 1100 ACL. All other opcodes are 1-byte.
//  - FETCH_OP
//    - Drive rom_addr=PC, rom_read=rom_ena=1.
//    - On the clock edge: capture rom_data into opcode/reg, set ir_pc=PC, PC<=PC+1.
//    - Two-byte opcode goes to FETCH_ARG; otherwise go to HOLD with ir_operand=0.
//  - FETCH_ARG
//    - Drive rom_addr=PC, rom_read=rom_ena=1.
//    - Capture ir_operand, PC<=PC+1, go to HOLD.
//  - HOLD
//    - rom_read=rom_ena=0; ir_valid=1.
//    - All ir_* outputs stay stable until ir_valid&&ir_ready.
//    - On the handshake: opcode 1111 (HLT) goes to HALTED; else go to FETCH_OP.
//  - HALTED: rom_read=rom_ena=0, ir_valid=0, halted=1. Leave only on pc_load or reset.
//  - Latency from FETCH_OP entry to ir_valid: 1 cycle for 1-byte, 2 cycles for 2-byte. Throughput: 1 instruction per 2 or 3 cycles.
//  - pc_load (any state, highest priority)
//    - PC<=pc_load_addr; state<=FETCH_OP; ir_valid=0 from the next cycle.
//    - Any partly fetched instruction is discarded.
//    - If it coincides with a HOLD handshake, the handshake completes (bundle consumed), then the redirect applies.
//    - A coinciding HLT does not halt.
//  - PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. A 2-byte opcode at 8'hFF takes its operand from 8'h00.
//  - rom_read and rom_ena are always driven equal; they are never high outside FETCH_OP/FETCH_ARG.
// CONFIGURATION
//  - FETCH_SKIP_NOP_EN defined
//    - An opcode byte with [7:4]=0000 (NOP) is consumed in FETCH_OP: PC<=PC+1, stay in FETCH_OP.
//    - Nothing is presented to decode; costs 1 cycle per NOP.
//  - FETCH_SKIP_NOP_EN undefined: NOP is a normal 1-byte instruction presented through HOLD.
// TESTING
//  1 Reset: rst_n low mid-FETCH_ARG -> same instant rom_read=0, ir_valid=0. After release, first cycle rom_addr=8'h00, rom_read=rom_ena=1.
//  2 Two-byte: ROM[1]=8'h11, ROM[2]=8'h41, ir_ready=1 -> bundle opcode=1, reg=1, operand=8'h41, ir_pc=1, ir_two_byte=1. Next fetch at addr 3.
//  3 Back-pressure: hold ir_ready=0 for 5 cycles on bundle 8'h62 -> outputs stable, rom_read=0. Accept on cycle 6, then fetch the next byte.
//  4 Redirect: JMP 8'h50 at 14/15; raise pc_load=1 with pc_load_addr=8'h17 during the handshake -> next rom_addr=8'h17, HLT at 16 never presented.
//  5 Halt: ROM[48]=8'hF0 accepted -> halted=1, rom_ena=0 indefinitely. Then pc_load to 8'h00 -> fetch resumes at 0, halted=0.
//  6 Wrap: pc_load to 8'hFF with ROM[FF]=8'h35, ROM[0]=8'h07 -> operand=8'h07, next fetch at 8'h01.
//  - Run tests 2 and 5 both with and without FETCH_SKIP_NOP_EN, using ROM[0]=8'h00: the NOP bundle appears only without the macro.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads 1- or 2-byte instructions from ROM
// and hands them to decode over valid/ready. Optional NOP skipping: FETCH_SKIP_NOP_EN.
`timescale 1ns/1ps

module instr_fetch #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rom_addr,
    output logic       rom_read,
    output logic       rom_ena,
    input  logic [7:0] rom_data,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [3:0] ir_opcode,
    output logic [3:0] ir_reg,
    output logic [7:0] ir_operand,
    output logic [7:0] ir_pc,
    output logic       ir_two_byte,
    input  logic       pc_load,
    input  logic [7:0] pc_load_addr,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        HOLD,
        HALTED
    } state_e;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_e     state_q;
    logic [7:0] pc_q, pc_d;
    logic [3:0] opcode_q, reg_q;
    logic [7:0] operand_q, ir_pc_q;
    logic       two_byte_q;
    logic       fetching;
    logic       skip_nop;

    function automatic logic is_two_byte(input logic [3:0] op);
        return op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1100};
    endfunction

`ifdef FETCH_SKIP_NOP_EN
    assign skip_nop = (rom_data[7:4] == OP_NOP);
`else
    assign skip_nop = 1'b0;
`endif

    assign fetching = (state_q == FETCH_OP) || (state_q == FETCH_ARG);

    // Strobes are gated by rst_n so an asserted reset drops them in the same instant.
    assign rom_addr    = pc_q;
    assign rom_read    = rst_n && fetching;
    assign rom_ena     = rst_n && fetching;
    assign ir_valid    = (state_q == HOLD);
    assign halted      = (state_q == HALTED);
    assign ir_opcode   = opcode_q;
    assign ir_reg      = reg_q;
    assign ir_operand  = operand_q;
    assign ir_pc       = ir_pc_q;
    assign ir_two_byte = two_byte_q;

    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_load_addr;
        end else if (fetching) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= START_ADDR;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_OP;
            opcode_q   <= 4'h0;
            reg_q      <= 4'h0;
            operand_q  <= 8'h00;
            ir_pc_q    <= 8'h00;
            two_byte_q <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins everywhere; a coinciding handshake has already consumed the bundle.
            state_q <= FETCH_OP;
        end else begin
            unique case (state_q)
                FETCH_OP: begin
                    opcode_q <= rom_data[7:4];
                    reg_q    <= rom_data[3:0];
                    ir_pc_q  <= pc_q;
                    if (skip_nop) begin
                        state_q <= FETCH_OP;
                    end else if (is_two_byte(rom_data[7:4])) begin
                        two_byte_q <= 1'b1;
                        state_q    <= FETCH_ARG;
                    end else begin
                        two_byte_q <= 1'b0;
                        operand_q  <= 8'h00;
                        state_q    <= HOLD;
                    end
                end
                FETCH_ARG: begin
                    operand_q <= rom_data;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (ir_ready) begin
                        state_q <= (opcode_q == OP_HLT) ? HALTED : FETCH_OP;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= FETCH_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scenario tasks plus randomized ROM runs
// compared against a byte-level fetch model. Honours FETCH_SKIP_NOP_EN.
`timescale 1ns/1ps

module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rom_addr;
    logic       rom_read, rom_ena;
    logic [7:0] rom_data;
    logic       ir_valid;
    logic       ir_ready = 1'b0;
    logic [3:0] ir_opcode, ir_reg;
    logic [7:0] ir_operand, ir_pc;
    logic       ir_two_byte;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_addr = 8'h00;
    logic       halted;

    logic [7:0] rom [256];
    logic [7:0] pc_m;
    logic       halt_m;
    int         compared = 0;
    int         mismatched = 0;

    instr_fetch #(.START_ADDR(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr     (rom_addr),
        .rom_read     (rom_read),
        .rom_ena      (rom_ena),
        .rom_data     (rom_data),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .ir_opcode    (ir_opcode),
        .ir_reg       (ir_reg),
        .ir_operand   (ir_operand),
        .ir_pc        (ir_pc),
        .ir_two_byte  (ir_two_byte),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .halted       (halted)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next bundle decode would see when fetching starts at pc; lat = edges until ir_valid.
    function automatic void model(input logic [7:0] pc, output logic [7:0] at,
                                  output logic [3:0] op, output logic [3:0] rg,
                                  output logic [7:0] operand, output logic two,
                                  output logic [7:0] nxt, output int lat);
        logic [7:0] a1;
        at  = pc;
        lat = 0;
`ifdef FETCH_SKIP_NOP_EN
        for (int i = 0; i < 256 && rom[at][7:4] == 4'h0; i++) begin
            at  = at + 8'd1;
            lat = lat + 1;
        end
`endif
        op      = rom[at][7:4];
        rg      = rom[at][3:0];
        two     = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'hC};
        a1      = at + 8'd1;
        operand = two ? rom[a1] : 8'h00;
        nxt     = two ? at + 8'd2 : at + 8'd1;
        lat     = lat + (two ? 2 : 1);
    endfunction

    // Waits for the next bundle, checks it, stalls ready_wait cycles, then accepts it.
    task automatic expect_next(input string name, input int ready_wait,
                               input logic redir, input logic [7:0] redir_addr);
        logic [7:0]  at, operand, nxt;
        logic [3:0]  op, rg;
        logic        two, halt_exp;
        logic [24:0] exp_b, got_b;
        int          lat, cnt;
        model(pc_m, at, op, rg, operand, two, nxt, lat);
        exp_b = {at, op, rg, operand, two};
        cnt = 0;
        while (ir_valid !== 1'b1 && cnt < 600) begin
            step();
            cnt++;
        end
        compared++;
        if (ir_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s timeout: ir_valid=%b after %0d cycles, required 1", name, ir_valid, cnt);
            return;
        end
        compared++;
        if (cnt != lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, cnt, lat);
        end
        compared++;
        got_b = {ir_pc, ir_opcode, ir_reg, ir_operand, ir_two_byte};
        if (got_b !== exp_b) begin
            mismatched++;
            $display("FAIL %s bundle {pc,op,reg,arg,two}: got %h, required %h", name, got_b, exp_b);
        end
        for (int i = 0; i < ready_wait; i++) begin
            step();
            compared++;
            got_b = {ir_pc, ir_opcode, ir_reg, ir_operand, ir_two_byte};
            if ({ir_valid, rom_read, rom_ena, got_b} !== {1'b1, 1'b0, 1'b0, exp_b}) begin
                mismatched++;
                $display("FAIL %s hold[%0d]: got valid=%b rd=%b ena=%b b=%h, required 1 0 0 %h",
                         name, i, ir_valid, rom_read, rom_ena, got_b, exp_b);
            end
        end
        ir_ready = 1'b1;
        if (redir) begin
            pc_load      = 1'b1;
            pc_load_addr = redir_addr;
        end
        step();
        ir_ready = 1'b0;
        pc_load  = 1'b0;
        pc_m     = redir ? redir_addr : nxt;
        halt_exp = (op == 4'hF) && !redir;
        halt_m   = halt_exp;
        compared++;
        if ({halted, ir_valid, rom_read, rom_addr} !== {halt_exp, 1'b0, !halt_exp, pc_m}) begin
            mismatched++;
            $display("FAIL %s after accept: got halted=%b valid=%b rd=%b addr=%h, required %b 0 %b %h",
                     name, halted, ir_valid, rom_read, rom_addr, halt_exp, !halt_exp, pc_m);
        end
    endtask

    task automatic redirect(input string name, input logic [7:0] addr);
        pc_load      = 1'b1;
        pc_load_addr = addr;
        step();
        pc_load = 1'b0;
        pc_m    = addr;
        halt_m  = 1'b0;
        compared++;
        if ({rom_addr, ir_valid, halted, rom_read, rom_ena} !== {addr, 4'b0011}) begin
            mismatched++;
            $display("FAIL %s redirect: got addr=%h valid=%b halted=%b rd=%b ena=%b, required %h 0 0 1 1",
                     name, rom_addr, ir_valid, halted, rom_read, rom_ena, addr);
        end
    endtask

    task automatic test_reset();
        #3;
        compared++;
        if ({rom_read, rom_ena, ir_valid, halted, rom_addr} !== {4'b0000, 8'h00}) begin
            mismatched++;
            $display("FAIL reset_held: got rd=%b ena=%b valid=%b halted=%b addr=%h, required 0 0 0 0 00",
                     rom_read, rom_ena, ir_valid, halted, rom_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        compared++;
        if ({rom_addr, rom_read} !== {8'h01, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_in_arg: got addr=%h rd=%b, required 01 1", rom_addr, rom_read);
        end
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if ({rom_read, rom_ena, ir_valid, halted, ir_opcode, ir_pc} !== {4'b0000, 4'h0, 8'h00}) begin
            mismatched++;
            $display("FAIL reset_abort: got rd=%b ena=%b valid=%b halted=%b op=%h pc=%h, required all 0",
                     rom_read, rom_ena, ir_valid, halted, ir_opcode, ir_pc);
        end
        #3 rst_n = 1'b1;
        #1;
        compared++;
        if ({rom_addr, rom_read, rom_ena, ir_valid} !== {8'h00, 3'b110}) begin
            mismatched++;
            $display("FAIL reset_release: got addr=%h rd=%b ena=%b valid=%b, required 00 1 1 0",
                     rom_addr, rom_read, rom_ena, ir_valid);
        end
        pc_m   = 8'h00;
        halt_m = 1'b0;
    endtask

    task automatic test_two_byte();
        rom[8'h00] = 8'h00;
`ifndef FETCH_SKIP_NOP_EN
        expect_next("nop_bundle", 0, 1'b0, 8'h00);
`endif
        expect_next("ldo_two_byte", 0, 1'b0, 8'h00);
        compared++;
        if (rom_addr !== 8'h03) begin
            mismatched++;
            $display("FAIL two_byte_next_addr: got %h, required 03", rom_addr);
        end
    endtask

    task automatic test_backpressure();
        rom[8'h03] = 8'h62;
        expect_next("backpressure", 5, 1'b0, 8'h00);
    endtask

    task automatic test_redirect();
        rom[8'h14] = 8'h50;
        rom[8'h15] = 8'($urandom);
        rom[8'h16] = 8'hF0;
        rom[8'h17] = 8'h2A;
        rom[8'h18] = 8'h77;
        rom[8'h40] = 8'h3C;
        redirect("to_jmp", 8'h14);
        expect_next("jmp_with_redirect", 1, 1'b1, 8'h17);
        expect_next("after_jmp", 0, 1'b0, 8'h00);
        redirect("to_hlt", 8'h16);
        expect_next("hlt_with_redirect", 0, 1'b1, 8'h40);
        step();
        redirect("mid_arg", 8'h18);
        expect_next("after_mid_arg", 0, 1'b0, 8'h00);
    endtask

    task automatic test_halt();
        rom[8'h30] = 8'hF0;
        redirect("to_halt", 8'h30);
        expect_next("hlt", 0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            compared++;
            if ({halted, rom_read, rom_ena, ir_valid} !== 4'b1000) begin
                mismatched++;
                $display("FAIL halted[%0d]: got halted=%b rd=%b ena=%b valid=%b, required 1 0 0 0",
                         i, halted, rom_read, rom_ena, ir_valid);
            end
        end
        rom[8'h00] = 8'h00;
        redirect("resume", 8'h00);
        expect_next("resume_first", 0, 1'b0, 8'h00);
    endtask

    task automatic test_wrap();
        rom[8'hFF] = 8'h35;
        rom[8'h00] = 8'h07;
        redirect("to_ff", 8'hFF);
        expect_next("wrap", 0, 1'b0, 8'h00);
        compared++;
        if (rom_addr !== 8'h01) begin
            mismatched++;
            $display("FAIL wrap_next_addr: got %h, required 01", rom_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        redirect("rand_start", 8'($urandom));
        for (int n = 0; n < 60; n++) begin
            if (halt_m) redirect("rand_unhalt", 8'($urandom));
            if ($urandom_range(0, 7) == 0)
                expect_next("rand_redir", $urandom_range(0, 3), 1'b1, 8'($urandom));
            else
                expect_next("rand", $urandom_range(0, 3), 1'b0, 8'h00);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h80;
        rom[8'h00] = 8'h11;
        rom[8'h01] = 8'h11;
        rom[8'h02] = 8'h41;
        test_reset();
        test_two_byte();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
